// File: rtl/jt12_sh_slot.sv
// jt12_sh_slot
// -----------------------------------------------------------------------------
// Time-multiplexed slot store for per-operator / per-channel state in the FM
// pipeline. A `stages`-deep, `width`-bit shift ring with clock enable, optional
// recirculation, slot-aligned write and bulk clear. A built-in slot counter
// reports which slot is currently at the ring end, so downstream logic does
// not need to track slots itself.
//
// Optional feature macro: JT12_SH_SLOT_TAP_EN
//   defined   : tap_out = mem[tap-1] (mid-ring observation point)
//   undefined : tap_out is tied to 0 and `tap` is not checked
//
// Ports:
//   clk     in   clock
//   rst     in   synchronous active-high reset
//   cen     in   clock enable for shifting and slot counting
//   we      in   stage 0 loads din instead of recirculated/default value
//   din     in   [width-1:0] write data
//   clr     in   bulk clear of all stages to rst_val (ignores cen)
//   drop    out  [width-1:0] data at ring end, mem[stages-1]
//   slot    out  [SW-1:0] index of the slot presented on drop
//   first   out  high while slot == 0
//   tap_out out  [width-1:0] mem[tap-1] when tap enabled, else 0
// -----------------------------------------------------------------------------
module jt12_sh_slot #(
  parameter int               width   = 5,
  parameter int               stages  = 24,
  parameter bit               recirc  = 1'b1,
  parameter logic [width-1:0] rst_val = '0,
  parameter int               tap     = 12,
  localparam int              SW      = (stages > 1) ? $clog2(stages) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             we,
  input  logic [width-1:0] din,
  input  logic             clr,
  output logic [width-1:0] drop,
  output logic [SW-1:0]    slot,
  output logic             first,
  output logic [width-1:0] tap_out
);

  // Last valid slot index; the counter wraps here so it never reaches
  // `stages`, even when `stages` is not a power of two.
  localparam logic [SW-1:0] LAST_SLOT = SW'(stages - 1);

  // Elaboration-time parameter legality.
  if (stages < 1) begin : g_bad_stages
    $error("jt12_sh_slot: stages must be >= 1 (got %0d)", stages);
  end

  logic [width-1:0] mem_q [stages];
  logic [width-1:0] mem_d [stages];
  logic [SW-1:0]    slot_q;
  logic [SW-1:0]    slot_d;

  // Next-state: shift/count on cen, then clr overrides the ring contents.
  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    mem_d  = mem_q;
    slot_d = slot_q;

    if (cen) begin
      slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + SW'(1);
      for (int k = stages - 1; k > 0; k--) begin
        mem_d[k] = mem_q[k-1];
      end
      if (we) begin
        mem_d[0] = din;
      end else if (recirc) begin
        mem_d[0] = mem_q[stages-1];
      end else begin
        mem_d[0] = rst_val;
      end
    end

    // Clear discards all slot data (including a concurrent write) but lets
    // the slot counter keep its cen-qualified progress.
    if (clr) begin
      for (int k = 0; k < stages; k++) begin
        mem_d[k] = rst_val;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the ring storage is reset on purpose: a slot must never expose
      // stale data after reset, so it is built from resettable flops rather
      // than RAM.
      for (int k = 0; k < stages; k++) begin
        mem_q[k] <= rst_val;
      end
      slot_q <= '0;
    end else begin
      mem_q  <= mem_d;
      slot_q <= slot_d;
    end
  end

  assign drop  = mem_q[stages-1];
  assign slot  = slot_q;
  assign first = (slot_q == '0);

`ifdef JT12_SH_SLOT_TAP_EN
  if ((tap < 1) || (tap > stages)) begin : g_bad_tap
    $error("jt12_sh_slot: tap must be in 1..stages (got %0d)", tap);
  end

  // Data written at slot c shows up here `tap` enabled edges later.
  assign tap_out = mem_q[tap-1];
`else
  // tap only matters when the mid-ring output is built.
  localparam int unused_tap = tap;

  assign tap_out = '0;
`endif

endmodule

// File: tb/tb_jt12_sh_slot.sv
// tb_jt12_sh_slot
// -----------------------------------------------------------------------------
// Directed testbench for jt12_sh_slot. Four instances cover the interesting
// configurations:
//   u_a : width 8, stages 4, recirc 1, rst_val 8'h5A  (reset, writes, cen, clr)
//   u_b : width 8, stages 4, recirc 0, rst_val 8'h5A  (no recirculation)
//   u_c : width 8, stages 5, recirc 1, rst_val 0, tap 2 (tap, non-pow2 wrap)
//   u_d : width 8, stages 1, recirc 1, rst_val 8'h3C  (single-stage ring)
// Each instance has its own stimulus signals; idle instances hold cen low.
// -----------------------------------------------------------------------------
module tb_jt12_sh_slot;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A ----------------
  logic       rst_a, cen_a, we_a, clr_a;
  logic [7:0] din_a, drop_a, tap_a;
  logic [1:0] slot_a;
  logic       first_a;

  jt12_sh_slot #(
    .width(8), .stages(4), .recirc(1'b1), .rst_val(8'h5A), .tap(2)
  ) u_a (
    .clk(clk), .rst(rst_a), .cen(cen_a), .we(we_a), .din(din_a), .clr(clr_a),
    .drop(drop_a), .slot(slot_a), .first(first_a), .tap_out(tap_a)
  );

  // ---------------- instance B ----------------
  logic       rst_b, cen_b, we_b, clr_b;
  logic [7:0] din_b, drop_b, tap_b;
  logic [1:0] slot_b;
  logic       first_b;

  jt12_sh_slot #(
    .width(8), .stages(4), .recirc(1'b0), .rst_val(8'h5A), .tap(1)
  ) u_b (
    .clk(clk), .rst(rst_b), .cen(cen_b), .we(we_b), .din(din_b), .clr(clr_b),
    .drop(drop_b), .slot(slot_b), .first(first_b), .tap_out(tap_b)
  );

  // ---------------- instance C ----------------
  logic       rst_c, cen_c, we_c, clr_c;
  logic [7:0] din_c, drop_c, tap_c;
  logic [2:0] slot_c;
  logic       first_c;

  jt12_sh_slot #(
    .width(8), .stages(5), .recirc(1'b1), .rst_val(8'h00), .tap(2)
  ) u_c (
    .clk(clk), .rst(rst_c), .cen(cen_c), .we(we_c), .din(din_c), .clr(clr_c),
    .drop(drop_c), .slot(slot_c), .first(first_c), .tap_out(tap_c)
  );

  // ---------------- instance D ----------------
  logic       rst_d, cen_d, we_d, clr_d;
  logic [7:0] din_d, drop_d, tap_d;
  logic [0:0] slot_d;
  logic       first_d;

  jt12_sh_slot #(
    .width(8), .stages(1), .recirc(1'b1), .rst_val(8'h3C), .tap(1)
  ) u_d (
    .clk(clk), .rst(rst_d), .cen(cen_d), .we(we_d), .din(din_d), .clr(clr_d),
    .drop(drop_d), .slot(slot_d), .first(first_d), .tap_out(tap_d)
  );

  // Expected tap_out for a given stored value in the current build.
  function automatic logic [31:0] texp(input logic [31:0] v);
`ifdef JT12_SH_SLOT_TAP_EN
    return v;
`else
    return 32'h0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_a [4];

  initial begin
    exp_a = '{8'h11, 8'h22, 8'h33, 8'h44};

    {rst_a, rst_b, rst_c, rst_d} = 4'b1111;
    {cen_a, cen_b, cen_c, cen_d} = 4'b1111;
    {we_a,  we_b,  we_c,  we_d } = 4'b0000;
    {clr_a, clr_b, clr_c, clr_d} = 4'b0000;
    din_a = '0; din_b = '0; din_c = '0; din_d = '0;

    // ---------- reset, 2 cycles with cen high ----------
    step();
    step();
    {rst_a, rst_b, rst_c, rst_d} = 4'b0000;
    {cen_b, cen_c, cen_d} = 3'b000;

    check("a_rst_drop",  32'(drop_a),  32'h5A);
    check("a_rst_slot",  32'(slot_a),  32'h0);
    check("a_rst_first", 32'(first_a), 32'h1);
    check("a_rst_tap",   32'(tap_a),   texp(32'h5A));

    // ---------- free rotation after reset, recirc=1 ----------
    for (int i = 1; i <= 4; i++) begin
      step();
      check("a_idle_slot", 32'(slot_a), 32'(i % 4));
      check("a_idle_drop", 32'(drop_a), 32'h5A);
      if (i == 1) check("a_idle_first", 32'(first_a), 32'h0);
    end
    check("a_idle_first_wrap", 32'(first_a), 32'h1);

    // ---------- slot-aligned writes at slots 0..3 ----------
    we_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din_a = exp_a[i];
      step();
    end
    we_a = 1'b0;
    check("a_wr_slot0", 32'(slot_a), 32'h0);
    check("a_wr_drop0", 32'(drop_a), 32'h11);
    for (int i = 1; i <= 8; i++) begin
      step();
      check("a_rot_slot", 32'(slot_a), 32'(i % 4));
      check("a_rot_drop", 32'(drop_a), 32'(exp_a[i % 4]));
    end

    // ---------- clock enable: 1,0,0,1 with a we pulse while disabled ----------
    cen_a = 1'b0;
    step();
    check("a_cen0_slot", 32'(slot_a), 32'h0);
    check("a_cen0_drop", 32'(drop_a), 32'h11);
    we_a = 1'b1; din_a = 8'hEE;
    step();
    check("a_cen0we_slot", 32'(slot_a), 32'h0);
    check("a_cen0we_drop", 32'(drop_a), 32'h11);
    we_a = 1'b0; cen_a = 1'b1;
    step();
    check("a_cen1_slot", 32'(slot_a), 32'h1);
    check("a_cen1_drop", 32'(drop_a), 32'h22);
    for (int i = 2; i <= 6; i++) begin
      step();
      check("a_cen_rot_slot", 32'(slot_a), 32'(i % 4));
      check("a_cen_rot_drop", 32'(drop_a), 32'(exp_a[i % 4]));
    end

    // ---------- clr + we at slot 2: clear wins, slot advances ----------
    check("a_pre_clr_slot", 32'(slot_a), 32'h2);
    clr_a = 1'b1; we_a = 1'b1; din_a = 8'hFF;
    step();
    clr_a = 1'b0; we_a = 1'b0;
    check("a_clr_slot", 32'(slot_a), 32'h3);
    check("a_clr_drop", 32'(drop_a), 32'h5A);
    for (int i = 0; i < 4; i++) begin
      step();
      check("a_clr_rot_drop", 32'(drop_a), 32'h5A);
    end

    // ---------- rst + clr together: rst wins, slot -> 0 ----------
    rst_a = 1'b1; clr_a = 1'b1;
    step();
    rst_a = 1'b0; clr_a = 1'b0;
    check("a_rstclr_slot",  32'(slot_a),  32'h0);
    check("a_rstclr_first", 32'(first_a), 32'h1);
    check("a_rstclr_drop",  32'(drop_a),  32'h5A);

    // ---------- clr with cen low: data cleared, slot holds ----------
    we_a = 1'b1; din_a = 8'h77;
    step();
    we_a = 1'b0; cen_a = 1'b0; clr_a = 1'b1;
    step();
    check("a_clr_cen0_slot", 32'(slot_a), 32'h1);
    clr_a = 1'b0; cen_a = 1'b1;
    step();
    step();
    step();
    check("a_clr_cen0_wrap", 32'(slot_a), 32'h0);
    check("a_clr_cen0_drop", 32'(drop_a), 32'h5A);

    // ---------- recirc=0: written data drains to rst_val ----------
    cen_b = 1'b1; we_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din_b = 8'(i + 1);
      step();
    end
    we_b = 1'b0;
    check("b_drop0", 32'(drop_b), 32'h01);
    for (int i = 1; i <= 7; i++) begin
      step();
      check("b_drop", 32'(drop_b), (i < 4) ? 32'(i + 1) : 32'h5A);
    end
    check("b_slot", 32'(slot_b), 32'h3);

    // ---------- tap and non-power-of-two wrap (stages=5, tap=2) ----------
    cen_c = 1'b1; we_c = 1'b1; din_c = 8'hA5;
    check("c_first0", 32'(first_c), 32'h1);
    step();
    we_c = 1'b0;
    check("c_slot1", 32'(slot_c), 32'h1);
    check("c_tap1",  32'(tap_c),  texp(32'h0));
    step();
    check("c_slot2", 32'(slot_c), 32'h2);
    check("c_tap2",  32'(tap_c),  texp(32'hA5));
    for (int i = 3; i <= 6; i++) begin
      step();
      check("c_slot", 32'(slot_c), 32'(i % 5));
      check("c_drop", 32'(drop_c), (i == 5) ? 32'hA5 : 32'h0);
    end
    check("c_first_off", 32'(first_c), 32'h0);

    // ---------- single-stage ring ----------
    cen_d = 1'b1;
    check("d_rst_drop", 32'(drop_d), 32'h3C);
    we_d = 1'b1; din_d = 8'h9A;
    step();
    we_d = 1'b0;
    check("d_wr_drop", 32'(drop_d), 32'h9A);
    for (int i = 0; i < 3; i++) begin
      step();
      check("d_hold_drop",  32'(drop_d),  32'h9A);
      check("d_hold_slot",  32'(slot_d),  32'h0);
      check("d_hold_first", 32'(first_d), 32'h1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
